// File: rtl/writeback_prim_assembler_pkg.sv
// Shared opcode, primitive-mode and FSM encodings for the writeback/primitive-assembly stage.
// Pure declarations only, so the package adds no latency and has no back-pressure behaviour.
package writeback_prim_assembler_pkg;

   localparam logic [7:0] OP_ADD            = 8'h01;
   localparam logic [7:0] OP_SETVERTEX      = 8'h70;
   localparam logic [7:0] OP_SETCOLOR       = 8'h71;
   localparam logic [7:0] OP_ROTATE         = 8'h72;
   localparam logic [7:0] OP_TRANSLATE      = 8'h73;
   localparam logic [7:0] OP_SCALE          = 8'h74;
   localparam logic [7:0] OP_BEGINPRIMITIVE = 8'h75;
   localparam logic [7:0] OP_ENDPRIMITIVE   = 8'h76;

   localparam int VERTEX_WIDTH_DEF = 30;
   localparam int GSR_WIDTH_DEF    = 6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2
   } state_e;

   typedef enum logic {
      PRIM_INDEP = 1'b0,
      PRIM_STRIP = 1'b1
   } prim_mode_e;

   function automatic logic is_gsr_op(input logic [7:0] op);
      return (op == OP_SETCOLOR) || (op == OP_ROTATE) ||
             (op == OP_TRANSLATE) || (op == OP_SCALE);
   endfunction

endpackage

// File: rtl/writeback_prim_assembler_prim_vertex_buffer.sv
// Vertex slot storage: indexed write or strip shift-in, updated on the falling edge.
// Flattened slots are combinational from the flops; no back-pressure of its own.
module writeback_prim_assembler_prim_vertex_buffer #(
   parameter int VERTEX_WIDTH   = 30,
   parameter int VERTS_PER_PRIM = 3,
   parameter int IDX_WIDTH      = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   wr_vld,
   input  logic [IDX_WIDTH-1:0]                   wr_idx,
   input  logic [VERTEX_WIDTH-1:0]                wr_dat,
   input  logic                                   shift_vld,
   output logic [VERTS_PER_PRIM*VERTEX_WIDTH-1:0] slots_dat
);

   logic [VERTEX_WIDTH-1:0] slot_q [VERTS_PER_PRIM];
   logic [VERTEX_WIDTH-1:0] slot_d [VERTS_PER_PRIM];

   always_comb begin
      slot_d = slot_q;
      if (shift_vld) begin
         // strip mode: oldest vertex falls out of slot 0, newest lands on top
         for (int i = 0; i < VERTS_PER_PRIM - 1; i++) begin
            slot_d[i] = slot_q[i+1];
         end
         slot_d[VERTS_PER_PRIM-1] = wr_dat;
      end else if (wr_vld) begin
         slot_d[wr_idx] = wr_dat;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < VERTS_PER_PRIM; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         slot_q <= slot_d;
      end
   end

   always_comb begin
      slots_dat = '0;
      for (int i = 0; i < VERTS_PER_PRIM; i++) begin
         slots_dat[i*VERTEX_WIDTH +: VERTEX_WIDTH] = slot_q[i];
      end
   end

endmodule

// File: rtl/writeback_prim_assembler.sv
// Writeback to decode plus primitive assembly for the GPU; 1-cycle registered outputs on the falling edge.
// Stalls upstream only while a primitive waits in EMIT against GPU stall; WB_PRIM_COUNTER_EN adds O_PrimCount.
module writeback_prim_assembler
   import writeback_prim_assembler_pkg::*;
#(
   parameter int REG_WIDTH      = 16,
   parameter int VREG_WIDTH     = 64,
   parameter int VREG_ID_WIDTH  = 6,
   parameter int VERTEX_WIDTH   = VERTEX_WIDTH_DEF,
   parameter int VERTS_PER_PRIM = 3,
   parameter int GSR_WIDTH      = GSR_WIDTH_DEF,
   parameter int PC_WIDTH       = 16
) (
   input  logic                                   I_CLOCK,
   input  logic                                   I_RESET,
   input  logic                                   I_LOCK,
   input  logic [7:0]                             I_Opcode,
   input  logic [31:0]                            I_IR,
   input  logic [PC_WIDTH-1:0]                    I_PC,
   input  logic [3:0]                             I_DestRegIdx,
   input  logic [REG_WIDTH-1:0]                   I_DestValue,
   input  logic                                   I_RegWEn,
   input  logic [2:0]                             I_CCValue,
   input  logic                                   I_CCWEn,
   input  logic [VREG_ID_WIDTH-1:0]               I_DestVRegIdx,
   input  logic [VREG_WIDTH-1:0]                  I_VecDestValue,
   input  logic                                   I_VRegWEn,
   input  logic [VREG_WIDTH-1:0]                  I_VecSrc1Value,
   input  logic                                   I_GPUStallSignal,
   output logic                                   O_LOCK,
   output logic [PC_WIDTH-1:0]                    O_PC,
   output logic [REG_WIDTH-1:0]                   O_WriteBackData,
   output logic [3:0]                             O_WriteBackRegIdx,
   output logic                                   O_RegWEn,
   output logic [2:0]                             O_CCValue,
   output logic                                   O_CCWEn,
   output logic [VREG_ID_WIDTH-1:0]               O_WriteBackVRegIdx,
   output logic [VREG_WIDTH-1:0]                  O_VecDestValue,
   output logic                                   O_VRegWEn,
   output logic                                   O_Stall,
   output logic [VERTS_PER_PRIM*VERTEX_WIDTH-1:0] O_Prim,
   output logic                                   O_PrimValid,
   output logic [GSR_WIDTH-1:0]                   O_GSRValue,
   output logic                                   O_GSRValue_Valid,
   output logic [15:0]                            O_PrimCount
);

   localparam int CW = (VERTS_PER_PRIM > 2) ? $clog2(VERTS_PER_PRIM) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(VERTS_PER_PRIM - 1);
   localparam int PW = VERTS_PER_PRIM * VERTEX_WIDTH;

   typedef struct packed {
      logic                     lock;
      logic [PC_WIDTH-1:0]      pc;
      logic [REG_WIDTH-1:0]     data;
      logic [3:0]               idx;
      logic                     reg_wen;
      logic [2:0]               cc;
      logic                     cc_wen;
      logic [VREG_ID_WIDTH-1:0] vidx;
      logic [VREG_WIDTH-1:0]    vdata;
      logic                     vreg_wen;
   } wb_t;

   wb_t            wb_q, wb_d;
   state_e         state_q, state_d;
   prim_mode_e     mode_q, mode_d;
   logic [CW-1:0]  count_q, count_d;
   logic           primed_q, primed_d;
   logic [PW-1:0]  prim_q, prim_d;
   logic           prim_vld_q, prim_vld_d;
   logic [GSR_WIDTH-1:0] gsr_q, gsr_d;
   logic           gsr_vld_q, gsr_vld_d;

   logic           stall, accept, emit;
   logic           wr_vld, shift_vld;
   logic [CW-1:0]  wr_idx;
   logic [PW-1:0]  slots_dat;
   logic           unused_bits;

   assign unused_bits = ^{I_IR[31:2], I_VecSrc1Value[VREG_WIDTH-1:VERTEX_WIDTH]};

   assign stall  = (state_q == ST_EMIT) & I_GPUStallSignal;
   assign accept = I_LOCK & ~stall;

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      count_d   = count_q;
      primed_d  = primed_q;
      emit      = 1'b0;
      wr_vld    = 1'b0;
      shift_vld = 1'b0;
      wr_idx    = count_q;

      // retire the pending primitive first; this cycle's opcode sees the post-emit state
      if ((state_q == ST_EMIT) && !I_GPUStallSignal) begin
         emit    = 1'b1;
         state_d = ST_COLLECT;
         if (mode_q == PRIM_INDEP) count_d = '0;
         else                      primed_d = 1'b1;
      end

      if (accept) begin
         if (I_Opcode == OP_BEGINPRIMITIVE) begin
            mode_d   = (I_IR[1:0] == 2'd1) ? PRIM_STRIP : PRIM_INDEP;
            count_d  = '0;
            primed_d = 1'b0;
            state_d  = ST_COLLECT;
         end else if ((I_Opcode == OP_SETVERTEX) && (state_d == ST_COLLECT)) begin
            if ((mode_d == PRIM_STRIP) && primed_d) begin
               shift_vld = 1'b1;
               state_d   = ST_EMIT;
            end else begin
               wr_vld = 1'b1;
               wr_idx = count_d;
               if (count_d == LAST_IDX) state_d = ST_EMIT;
               else                     count_d = count_d + 1'b1;
            end
         end else if ((I_Opcode == OP_ENDPRIMITIVE) && (state_d == ST_COLLECT)) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            primed_d = 1'b0;
         end
      end
   end

   always_comb begin
      wb_d.lock     = accept;
      wb_d.pc       = I_PC;
      wb_d.data     = I_DestValue;
      wb_d.idx      = I_DestRegIdx;
      wb_d.reg_wen  = accept & I_RegWEn;
      wb_d.cc       = I_CCValue;
      wb_d.cc_wen   = accept & I_CCWEn;
      wb_d.vidx     = I_DestVRegIdx;
      wb_d.vdata    = I_VecDestValue;
      wb_d.vreg_wen = accept & I_VRegWEn;

      prim_vld_d = emit;
      prim_d     = emit ? slots_dat : prim_q;
      gsr_vld_d  = accept & is_gsr_op(I_Opcode);
      gsr_d      = gsr_vld_d ? I_VecSrc1Value[GSR_WIDTH-1:0] : gsr_q;
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         wb_q       <= '0;
         state_q    <= ST_IDLE;
         mode_q     <= PRIM_INDEP;
         count_q    <= '0;
         primed_q   <= 1'b0;
         prim_q     <= '0;
         prim_vld_q <= 1'b0;
         gsr_q      <= '0;
         gsr_vld_q  <= 1'b0;
      end else begin
         wb_q       <= wb_d;
         state_q    <= state_d;
         mode_q     <= mode_d;
         count_q    <= count_d;
         primed_q   <= primed_d;
         prim_q     <= prim_d;
         prim_vld_q <= prim_vld_d;
         gsr_q      <= gsr_d;
         gsr_vld_q  <= gsr_vld_d;
      end
   end

   writeback_prim_assembler_prim_vertex_buffer #(
      .VERTEX_WIDTH   (VERTEX_WIDTH),
      .VERTS_PER_PRIM (VERTS_PER_PRIM),
      .IDX_WIDTH      (CW)
   ) u_vbuf (
      .clk       (I_CLOCK),
      .rst       (I_RESET),
      .wr_vld    (wr_vld),
      .wr_idx    (wr_idx),
      .wr_dat    (I_VecSrc1Value[VERTEX_WIDTH-1:0]),
      .shift_vld (shift_vld),
      .slots_dat (slots_dat)
   );

`ifdef WB_PRIM_COUNTER_EN
   logic [15:0] prim_count_q, prim_count_d;

   // counts alongside the strobe so O_PrimCount already includes the primitive on O_Prim
   always_comb begin
      prim_count_d = emit ? (prim_count_q + 16'd1) : prim_count_q;
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) prim_count_q <= '0;
      else         prim_count_q <= prim_count_d;
   end

   assign O_PrimCount = prim_count_q;
`else
   assign O_PrimCount = '0;
`endif

   assign O_LOCK             = wb_q.lock;
   assign O_PC               = wb_q.pc;
   assign O_WriteBackData    = wb_q.data;
   assign O_WriteBackRegIdx  = wb_q.idx;
   assign O_RegWEn           = wb_q.reg_wen;
   assign O_CCValue          = wb_q.cc;
   assign O_CCWEn            = wb_q.cc_wen;
   assign O_WriteBackVRegIdx = wb_q.vidx;
   assign O_VecDestValue     = wb_q.vdata;
   assign O_VRegWEn          = wb_q.vreg_wen;
   assign O_Stall            = stall;
   assign O_Prim             = prim_q;
   assign O_PrimValid        = prim_vld_q;
   assign O_GSRValue         = gsr_q;
   assign O_GSRValue_Valid   = gsr_vld_q;

endmodule

// File: tb/tb_writeback_prim_assembler.sv
// Directed bench for writeback_prim_assembler: writeback, INDEP/STRIP assembly, stall, reset, GSR, counter.
module tb_writeback_prim_assembler;
   import writeback_prim_assembler_pkg::*;

   logic        I_CLOCK, I_RESET, I_LOCK;
   logic [7:0]  I_Opcode;
   logic [31:0] I_IR;
   logic [15:0] I_PC;
   logic [3:0]  I_DestRegIdx;
   logic [15:0] I_DestValue;
   logic        I_RegWEn;
   logic [2:0]  I_CCValue;
   logic        I_CCWEn;
   logic [5:0]  I_DestVRegIdx;
   logic [63:0] I_VecDestValue;
   logic        I_VRegWEn;
   logic [63:0] I_VecSrc1Value;
   logic        I_GPUStallSignal;
   logic        O_LOCK;
   logic [15:0] O_PC;
   logic [15:0] O_WriteBackData;
   logic [3:0]  O_WriteBackRegIdx;
   logic        O_RegWEn;
   logic [2:0]  O_CCValue;
   logic        O_CCWEn;
   logic [5:0]  O_WriteBackVRegIdx;
   logic [63:0] O_VecDestValue;
   logic        O_VRegWEn;
   logic        O_Stall;
   logic [89:0] O_Prim;
   logic        O_PrimValid;
   logic [5:0]  O_GSRValue;
   logic        O_GSRValue_Valid;
   logic [15:0] O_PrimCount;

   int pass_cnt = 0;
   int total    = 0;
   int strobe_cnt = 0;
   logic [89:0] prims [$];

   writeback_prim_assembler dut (
      .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_Opcode(I_Opcode),
      .I_IR(I_IR), .I_PC(I_PC), .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue),
      .I_RegWEn(I_RegWEn), .I_CCValue(I_CCValue), .I_CCWEn(I_CCWEn),
      .I_DestVRegIdx(I_DestVRegIdx), .I_VecDestValue(I_VecDestValue), .I_VRegWEn(I_VRegWEn),
      .I_VecSrc1Value(I_VecSrc1Value), .I_GPUStallSignal(I_GPUStallSignal),
      .O_LOCK(O_LOCK), .O_PC(O_PC), .O_WriteBackData(O_WriteBackData),
      .O_WriteBackRegIdx(O_WriteBackRegIdx), .O_RegWEn(O_RegWEn), .O_CCValue(O_CCValue),
      .O_CCWEn(O_CCWEn), .O_WriteBackVRegIdx(O_WriteBackVRegIdx),
      .O_VecDestValue(O_VecDestValue), .O_VRegWEn(O_VRegWEn), .O_Stall(O_Stall),
      .O_Prim(O_Prim), .O_PrimValid(O_PrimValid), .O_GSRValue(O_GSRValue),
      .O_GSRValue_Valid(O_GSRValue_Valid), .O_PrimCount(O_PrimCount)
   );

   initial I_CLOCK = 1'b0;
   always #5 I_CLOCK = ~I_CLOCK;

   // outputs settle on the falling edge, so the rising edge is a quiet sampling point
   always @(posedge I_CLOCK) begin
      if (O_PrimValid === 1'b1) begin
         prims.push_back(O_Prim);
         strobe_cnt++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

   task automatic tick();
      @(posedge I_CLOCK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle();
      I_LOCK = 1'b0; I_Opcode = 8'h00; I_IR = '0; I_PC = '0;
      I_DestRegIdx = '0; I_DestValue = '0; I_RegWEn = 1'b0;
      I_CCValue = '0; I_CCWEn = 1'b0; I_DestVRegIdx = '0;
      I_VecDestValue = '0; I_VRegWEn = 1'b0; I_VecSrc1Value = '0;
   endtask

   task automatic put(input logic [7:0] op, input logic [31:0] ir, input logic [63:0] src);
      idle();
      I_LOCK = 1'b1; I_Opcode = op; I_IR = ir; I_VecSrc1Value = src;
   endtask

   function automatic logic [89:0] p3(input logic [29:0] a, input logic [29:0] b,
                                      input logic [29:0] c);
      return {c, b, a};
   endfunction

   initial begin
      idle();
      I_GPUStallSignal = 1'b0;
      I_RESET = 1'b1;
      tick(); tick();
      chk("rst_lock",    {127'd0, O_LOCK},      128'd0);
      chk("rst_regwen",  {127'd0, O_RegWEn},    128'd0);
      chk("rst_primvld", {127'd0, O_PrimValid}, 128'd0);
      chk("rst_prim",    {38'd0, O_Prim},       128'd0);
      chk("rst_gsrvld",  {127'd0, O_GSRValue_Valid}, 128'd0);
      chk("rst_stall",   {127'd0, O_Stall},     128'd0);
      chk("rst_count",   {112'd0, O_PrimCount}, 128'd0);
      chk("rst_data",    {112'd0, O_WriteBackData}, 128'd0);
      I_RESET = 1'b0;

      // plain writeback with every enable set, then the same data without I_LOCK
      I_LOCK = 1'b1; I_Opcode = OP_ADD; I_PC = 16'h0042; I_DestRegIdx = 4'd5;
      I_DestValue = 16'hBEEF; I_RegWEn = 1'b1; I_CCValue = 3'b101; I_CCWEn = 1'b1;
      I_DestVRegIdx = 6'd9; I_VecDestValue = 64'h0123_4567_89AB_CDEF; I_VRegWEn = 1'b1;
      tick();
      chk("wb_lock",   {127'd0, O_LOCK},            128'd1);
      chk("wb_pc",     {112'd0, O_PC},              128'h42);
      chk("wb_data",   {112'd0, O_WriteBackData},   128'hBEEF);
      chk("wb_idx",    {124'd0, O_WriteBackRegIdx}, 128'd5);
      chk("wb_regwen", {127'd0, O_RegWEn},          128'd1);
      chk("wb_cc",     {125'd0, O_CCValue},         128'd5);
      chk("wb_ccwen",  {127'd0, O_CCWEn},           128'd1);
      chk("wb_vidx",   {122'd0, O_WriteBackVRegIdx}, 128'd9);
      chk("wb_vdata",  {64'd0, O_VecDestValue},     128'h0123_4567_89AB_CDEF);
      chk("wb_vwen",   {127'd0, O_VRegWEn},         128'd1);
      I_LOCK = 1'b0; I_DestValue = 16'h5A5A;
      tick();
      chk("nolock_lock",  {127'd0, O_LOCK},    128'd0);
      chk("nolock_wen",   {125'd0, O_RegWEn, O_CCWEn, O_VRegWEn}, 128'd0);
      chk("nolock_data",  {112'd0, O_WriteBackData}, 128'h5A5A);
      idle();

      // reset in the middle of a primitive, then SETVERTEX without BEGIN is ignored
      prims.delete();
      put(OP_BEGINPRIMITIVE, 32'd0, 64'd0); tick();
      put(OP_SETVERTEX, 32'd0, 64'h11); tick();
      put(OP_SETVERTEX, 32'd0, 64'h22); tick();
      idle(); I_RESET = 1'b1; #2; I_RESET = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin put(OP_SETVERTEX, 32'd0, 64'h33); tick(); end
      idle(); tick(); tick();
      chk("reset_idle_sv", prims.size(), 128'd0);
      put(OP_BEGINPRIMITIVE, 32'd0, 64'd0); tick();
      for (int v = 7; v <= 9; v++) begin put(OP_SETVERTEX, 32'd0, 64'(v)); tick(); end
      idle(); tick(); tick();
      chk("reset_count", prims.size(), 128'd1);
      if (prims.size() >= 1) chk("reset_prim", {38'd0, prims[0]}, {38'd0, p3(7, 8, 9)});

      // independent triangles, back to back
      prims.delete();
      put(OP_BEGINPRIMITIVE, 32'd0, 64'd0); tick();
      for (int v = 1; v <= 6; v++) begin put(OP_SETVERTEX, 32'd0, 64'(v)); tick(); end
      idle(); tick(); tick();
      chk("indep_count", prims.size(), 128'd2);
      if (prims.size() >= 2) begin
         chk("indep_p0", {38'd0, prims[0]}, {38'd0, p3(1, 2, 3)});
         chk("indep_p1", {38'd0, prims[1]}, {38'd0, p3(4, 5, 6)});
      end

      // strip: each vertex after the first three emits a new primitive
      prims.delete();
      put(OP_BEGINPRIMITIVE, 32'd1, 64'd0); tick();
      for (int v = 1; v <= 5; v++) begin put(OP_SETVERTEX, 32'd0, 64'(v)); tick(); end
      put(OP_ENDPRIMITIVE, 32'd0, 64'd0); tick();
      idle(); tick(); tick();
      chk("strip_count", prims.size(), 128'd3);
      if (prims.size() >= 3) begin
         chk("strip_p0", {38'd0, prims[0]}, {38'd0, p3(1, 2, 3)});
         chk("strip_p1", {38'd0, prims[1]}, {38'd0, p3(2, 3, 4)});
         chk("strip_p2", {38'd0, prims[2]}, {38'd0, p3(3, 4, 5)});
      end

      // GPU stall held for four cycles with an ADD waiting
      prims.delete();
      put(OP_BEGINPRIMITIVE, 32'd0, 64'd0); tick();
      put(OP_SETVERTEX, 32'd0, 64'hA); tick();
      put(OP_SETVERTEX, 32'd0, 64'hB); tick();
      put(OP_SETVERTEX, 32'd0, 64'hC); tick();
      idle();
      I_LOCK = 1'b1; I_Opcode = OP_ADD; I_DestRegIdx = 4'd2; I_DestValue = 16'h1234;
      I_RegWEn = 1'b1; I_GPUStallSignal = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_high", {127'd0, O_Stall}, 128'd1);
         tick();
         chk("stall_regwen", {127'd0, O_RegWEn}, 128'd0);
         chk("stall_primvld", {127'd0, O_PrimValid}, 128'd0);
      end
      I_GPUStallSignal = 1'b0;
      #1;
      chk("stall_low", {127'd0, O_Stall}, 128'd0);
      tick();
      chk("release_regwen", {127'd0, O_RegWEn}, 128'd1);
      chk("release_data", {112'd0, O_WriteBackData}, 128'h1234);
      chk("release_idx", {124'd0, O_WriteBackRegIdx}, 128'd2);
      chk("release_primvld", {127'd0, O_PrimValid}, 128'd1);
      chk("release_prim", {38'd0, O_Prim}, {38'd0, p3(30'hA, 30'hB, 30'hC)});
      put(OP_SETVERTEX, 32'd0, 64'hD); tick();
      chk("release_once", {127'd0, O_RegWEn}, 128'd0);
      put(OP_SETVERTEX, 32'd0, 64'hE); tick();
      put(OP_SETVERTEX, 32'd0, 64'hF); tick();
      idle(); tick(); tick();
      chk("stall_count", prims.size(), 128'd2);
      if (prims.size() >= 2) chk("stall_p1", {38'd0, prims[1]}, {38'd0, p3(30'hD, 30'hE, 30'hF)});

      // ENDPRIMITIVE drops a partial primitive and returns to IDLE
      prims.delete();
      put(OP_BEGINPRIMITIVE, 32'd0, 64'd0); tick();
      put(OP_SETVERTEX, 32'd0, 64'h21); tick();
      put(OP_SETVERTEX, 32'd0, 64'h22); tick();
      put(OP_ENDPRIMITIVE, 32'd0, 64'd0); tick();
      for (int i = 0; i < 3; i++) begin put(OP_SETVERTEX, 32'd0, 64'h23); tick(); end
      idle(); tick(); tick();
      chk("end_no_prim", prims.size(), 128'd0);

      // graphics state updates
      put(OP_SETCOLOR, 32'd0, 64'hEA); tick();
      chk("color_val", {122'd0, O_GSRValue}, 128'h2A);
      chk("color_vld", {127'd0, O_GSRValue_Valid}, 128'd1);
      idle(); tick();
      chk("color_strobe_end", {127'd0, O_GSRValue_Valid}, 128'd0);
      chk("color_hold", {122'd0, O_GSRValue}, 128'h2A);
      put(OP_ROTATE, 32'd0, 64'h15); tick();
      chk("rotate_val", {122'd0, O_GSRValue}, 128'h15);
      chk("rotate_vld", {127'd0, O_GSRValue_Valid}, 128'd1);
      idle(); tick();

`ifdef WB_PRIM_COUNTER_EN
      chk("count_track", {112'd0, O_PrimCount}, {112'd0, strobe_cnt[15:0]});
      put(OP_BEGINPRIMITIVE, 32'd1, 64'd0); tick();
      for (int g = 0; g < 70000 && strobe_cnt < 65535; g++) begin
         put(OP_SETVERTEX, 32'd0, 64'(g & 32'hFF)); tick();
      end
      chk("count_budget", strobe_cnt, 128'd65535);
      chk("count_ffff", {112'd0, O_PrimCount}, 128'hFFFF);
      idle(); tick();
      chk("count_wrap_vld", {127'd0, O_PrimValid}, 128'd1);
      chk("count_wrap", {112'd0, O_PrimCount}, 128'd0);
`else
      chk("count_tied", {112'd0, O_PrimCount}, 128'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
